// File: rtl/alu_serial_div_pkg.sv
// Opcode encoding shared by the ALU and the serial divider.
package alu_serial_div_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_DIV  = 3'd4,
        ALU_DIVU = 3'd5,
        ALU_REM  = 3'd6,
        ALU_REMU = 3'd7
    } alu_opcode_e;

endpackage

// File: rtl/alu_serial_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with the EX-stage
// enable/ready handshake; one quotient bit per cycle, result held until accepted.
module alu_serial_div
    import alu_serial_div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter bit          ZERO_FAST_PATH = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  ex_ready_i,
    input  alu_opcode_e           operator_i,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  ready_o
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    quo_q;
    logic [W-1:0]    rem_q;
    logic [W-1:0]    div_q;
    logic            sign_q_q;
    logic            sign_r_q;
    logic            is_rem_q;
    logic            b_zero_q;
    logic [W-1:0]    result_q;

    logic            is_div_c;
    logic            is_signed_c;
    logic            is_rem_c;
    logic            a_neg_c;
    logic            b_neg_c;
    logic [W-1:0]    a_mag_c;
    logic [W-1:0]    b_mag_c;
    logic            b_zero_c;
    logic            start_c;
    logic            calc_last_c;
    logic [W:0]      rem_shift_c;
    logic [W:0]      rem_sub_c;
    logic            ge_c;
    logic [W-1:0]    rem_step_c;
    logic [W-1:0]    quo_step_c;
    logic [W-1:0]    quo_res_c;
    logic [W-1:0]    rem_res_c;

    // Opcode decode and operand magnitudes for the capture edge
    always_comb begin
        is_div_c    = operator_i inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        is_signed_c = (operator_i == ALU_DIV) || (operator_i == ALU_REM);
        is_rem_c    = (operator_i == ALU_REM) || (operator_i == ALU_REMU);
        a_neg_c     = is_signed_c & operand_a_i[W-1];
        b_neg_c     = is_signed_c & operand_b_i[W-1];
        a_mag_c     = a_neg_c ? W'(W'(0) - operand_a_i) : operand_a_i;
        b_mag_c     = b_neg_c ? W'(W'(0) - operand_b_i) : operand_b_i;
        b_zero_c    = (operand_b_i == '0);
    end

    // One restoring step; the borrow of the widened subtraction decides the quotient bit
    always_comb begin
        rem_shift_c = {rem_q, quo_q[W-1]};
        rem_sub_c   = rem_shift_c - {1'b0, div_q};
        ge_c        = ~rem_sub_c[W];
        rem_step_c  = ge_c ? rem_sub_c[W-1:0] : rem_shift_c[W-1:0];
        quo_step_c  = {quo_q[W-2:0], ge_c};
        quo_res_c   = (sign_q_q && !b_zero_q) ? W'(W'(0) - quo_step_c) : quo_step_c;
        rem_res_c   = sign_r_q ? W'(W'(0) - rem_step_c) : rem_step_c;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_d     = state_q;
        ready_o     = 1'b0;
        start_c     = 1'b0;
        calc_last_c = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = !(enable_i && is_div_c);
                if (enable_i && is_div_c) begin
                    start_c = 1'b1;
                    state_d = (ZERO_FAST_PATH && b_zero_c) ? FINISH : CALC;
                end
            end
            CALC: begin
                if (cnt_q == CW'(W - 1)) begin
                    calc_last_c = 1'b1;
                    state_d     = FINISH;
                end
            end
            FINISH: begin
                ready_o = 1'b1;
                if (ex_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            ready_o = 1'b0;
        end
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            is_rem_q <= 1'b0;
            b_zero_q <= 1'b0;
            result_q <= '0;
        end else if (start_c) begin
            cnt_q    <= '0;
            quo_q    <= a_mag_c;
            rem_q    <= '0;
            div_q    <= b_mag_c;
            sign_q_q <= a_neg_c ^ b_neg_c;
            sign_r_q <= a_neg_c;
            is_rem_q <= is_rem_c;
            b_zero_q <= b_zero_c;
            if (ZERO_FAST_PATH && b_zero_c) begin
                result_q <= is_rem_c ? operand_a_i : '1;
            end
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q + 1'b1;
            quo_q <= quo_step_c;
            rem_q <= rem_step_c;
            if (calc_last_c) begin
                result_q <= is_rem_q ? rem_res_c : quo_res_c;
            end
        end
    end

    assign result_o = result_q;

endmodule
